// File: rtl/mtx_burst_sched.sv
// Burst scheduler: per burst it runs SYNC -> GUARD -> TX -> GAP, repeated nburst times after a trigger edge.
// Optional WAIT_RDY watchdog enabled by `define MTX_BURST_SCHED_RDY_TIMEOUT_EN.
module mtx_burst_sched #(
  parameter int CNT_WIDTH   = 24,
  parameter int SYNC_LEN    = 8400,
  parameter int GUARD_LEN   = 8400,
  parameter int TX_LEN      = 40960,
  parameter int GAP_LEN     = 1024,
  parameter int NB_WIDTH    = 8,
  parameter int RDY_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig_in,
  input  logic                abort,
  input  logic [NB_WIDTH-1:0] nburst,
  input  logic                sig_ready,
  output logic                sig_srst,
  output logic                sync_out,
  output logic                tx_valid,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                err,
  output logic [NB_WIDTH-1:0] burst_idx
);

  if (SYNC_LEN < 1 || GUARD_LEN < 1 || TX_LEN < 1 || GAP_LEN < 1 || RDY_TIMEOUT < 1) begin : g_bad_param
    $error("mtx_burst_sched: all phase lengths and RDY_TIMEOUT must be >= 1");
  end

  localparam logic [CNT_WIDTH-1:0] SYNC_LAST  = CNT_WIDTH'(SYNC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] TX_LAST    = CNT_WIDTH'(TX_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(GAP_LEN - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SYNC, GUARD, TX, GAP} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [NB_WIDTH-1:0]  nb_lat;
  logic                 trig_s1, trig_s2, trig_s3;
  logic                 vld_s1, vld_s2, armed;
  logic                 start, last_burst, cnt_run;
  logic                 latch, inc_idx, done_nxt, aborted_nxt;

  // Trigger synchroniser; armed only after a genuine low level has been seen
  // so a trigger held high across reset release never counts as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
      vld_s1  <= 1'b0;
      vld_s2  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      trig_s1 <= trig_in;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      vld_s1  <= 1'b1;
      vld_s2  <= vld_s1;
      armed   <= armed | (vld_s2 & ~trig_s2);
    end
  end

  assign start      = trig_s2 & ~trig_s3 & armed;
  assign last_burst = (burst_idx == (nb_lat - NB_WIDTH'(1)));

`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] RDY_LAST = CNT_WIDTH'(RDY_TIMEOUT - 1);
  logic err_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    latch       = 1'b0;
    inc_idx     = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    cnt_run     = (state == SYNC) || (state == GUARD) || (state == TX) || (state == GAP);
`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
    err_nxt     = 1'b0;
    cnt_run     = cnt_run || (state == WAIT_RDY);
`endif
    case (state)
      IDLE: begin
        if (start && (nburst != '0)) begin
          state_nxt = WAIT_RDY;
          latch     = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (sig_ready) begin
          state_nxt = SYNC;
        end
`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
        else if (cnt == RDY_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
`endif
      end
      SYNC:  if (cnt == SYNC_LAST)  state_nxt = GUARD;
      GUARD: if (cnt == GUARD_LAST) state_nxt = TX;
      TX:    if (cnt == TX_LAST)    state_nxt = GAP;
      GAP: begin
        if (cnt == GAP_LAST) begin
          if (last_burst) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SYNC;
            inc_idx   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every other outcome, including the final GAP exit.
    if (abort && (state != IDLE)) begin
      state_nxt   = IDLE;
      aborted_nxt = 1'b1;
      done_nxt    = 1'b0;
      inc_idx     = 1'b0;
`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
      err_nxt     = 1'b0;
`endif
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      nb_lat    <= '0;
      burst_idx <= '0;
      sig_srst  <= 1'b1;
      sync_out  <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (latch) begin
        nb_lat    <= nburst;
        burst_idx <= '0;
      end else if (inc_idx) begin
        burst_idx <= burst_idx + NB_WIDTH'(1);
      end
      sig_srst <= (state_nxt != TX);
      sync_out <= (state_nxt == SYNC);
      tx_valid <= (state_nxt == TX);
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      aborted  <= aborted_nxt;
    end
  end

`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mtx_burst_sched.sv
// Directed bench for mtx_burst_sched using short phase lengths (SYNC 4, GUARD 3, TX 5, GAP 2).
module tb_mtx_burst_sched;

  localparam int NBW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           trig_in;
  logic           abort;
  logic [NBW-1:0] nburst;
  logic           sig_ready;
  logic           sig_srst, sync_out, tx_valid, busy, done, aborted, err;
  logic [NBW-1:0] burst_idx;

  int n_vec = 0;
  int n_err = 0;

  mtx_burst_sched #(
    .CNT_WIDTH(16), .SYNC_LEN(4), .GUARD_LEN(3), .TX_LEN(5), .GAP_LEN(2),
    .NB_WIDTH(NBW), .RDY_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .trig_in(trig_in), .abort(abort), .nburst(nburst),
    .sig_ready(sig_ready), .sig_srst(sig_srst), .sync_out(sync_out), .tx_valid(tx_valid),
    .busy(busy), .done(done), .aborted(aborted), .err(err), .burst_idx(burst_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig_in = 1'b0;
    repeat (3) tick();
    trig_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n_sync, n_tx, n_ovl, n_done, done_at, n_srst_tx, n_busy, err_at, n_err_pulse;
    reset = 1'b1; trig_in = 1'b0; abort = 1'b0; nburst = 8'd2; sig_ready = 1'b1;
    repeat (3) tick();
    chk("rst_srst", 32'(sig_srst), 32'd1);
    chk("rst_sync", 32'(sync_out), 32'd0);
    chk("rst_tx",   32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({done, aborted, err}), 32'd0);
    chk("rst_idx",  32'(burst_idx), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Two-burst run; nburst changed mid-run must not matter
    pulse_trig();
    tick(); tick();
    chk("a_busy_early", 32'(busy), 32'd0);
    tick();
    chk("a_busy_lat3", 32'(busy), 32'd1);
    chk("a_sync_wait", 32'(sync_out), 32'd0);
    trig_in = 1'b0;
    n_sync = 0; n_tx = 0; n_ovl = 0; n_done = 0; done_at = -1; n_srst_tx = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) chk("a_sync_first", 32'(sync_out), 32'd1);
      if (k == 2) nburst = 8'd5;
      if (k == 10) chk("a_idx0", 32'(burst_idx), 32'd0);
      if (k == 24) chk("a_idx1", 32'(burst_idx), 32'd1);
      n_sync += int'(sync_out);
      n_tx   += int'(tx_valid);
      n_ovl  += int'(sync_out & tx_valid);
      n_srst_tx += int'(sig_srst & tx_valid);
      if (done) begin n_done++; if (done_at < 0) done_at = k; end
    end
    chk("a_sync_cycles", 32'(n_sync), 32'd8);
    chk("a_tx_cycles", 32'(n_tx), 32'd10);
    chk("a_overlap", 32'(n_ovl), 32'd0);
    chk("a_srst_in_tx", 32'(n_srst_tx), 32'd0);
    chk("a_done_count", 32'(n_done), 32'd1);
    chk("a_done_cycle", 32'(done_at), 32'd29);
    chk("a_busy_end", 32'(busy), 32'd0);

    // nburst == 0 start ignored
    nburst = 8'd0;
    pulse_trig();
    n_busy = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_busy += int'(busy | sync_out | tx_valid | done);
    end
    chk("b_nburst0_activity", 32'(n_busy), 32'd0);

    // Abort during TX
    nburst = 8'd2;
    pulse_trig();
    for (int i = 0; i < 40 && !tx_valid; i++) tick();
    chk("c_tx_seen", 32'(tx_valid), 32'd1);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("c_aborted", 32'(aborted), 32'd1);
    chk("c_tx_off", 32'(tx_valid), 32'd0);
    chk("c_busy_off", 32'(busy), 32'd0);
    chk("c_srst_on", 32'(sig_srst), 32'd1);
    tick();
    chk("c_aborted_1cyc", 32'(aborted), 32'd0);
    n_done = 0;
    for (int k = 0; k < 30; k++) begin tick(); n_done += int'(done); end
    chk("c_no_done", 32'(n_done), 32'd0);

    // Abort while idle is ignored
    abort = 1'b1;
    repeat (2) tick();
    chk("d_idle_abort", 32'(aborted), 32'd0);
    abort = 1'b0;

    // Abort coincident with final GAP exit
    nburst = 8'd1;
    pulse_trig();
    for (int i = 0; i < 40 && !tx_valid; i++) tick();
    chk("e_tx_seen", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 20 && tx_valid; i++) tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("e_aborted", 32'(aborted), 32'd1);
    chk("e_done", 32'(done), 32'd0);
    chk("e_busy", 32'(busy), 32'd0);
    tick();
    chk("e_done_late", 32'(done), 32'd0);

    // sig_ready held low in WAIT_RDY
    sig_ready = 1'b0;
    pulse_trig();
    repeat (3) tick();
    chk("f_busy", 32'(busy), 32'd1);
    err_at = -1; n_err_pulse = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (err) begin n_err_pulse++; if (err_at < 0) err_at = k; end
    end
`ifdef MTX_BURST_SCHED_RDY_TIMEOUT_EN
    chk("f_err_cycle", 32'(err_at), 32'd20);
    chk("f_err_pulses", 32'(n_err_pulse), 32'd1);
    chk("f_idle", 32'(busy), 32'd0);
    sig_ready = 1'b1;
`else
    chk("f_err_none", 32'(n_err_pulse), 32'd0);
    chk("f_still_wait", 32'(busy), 32'd1);
    chk("f_no_sync", 32'(sync_out), 32'd0);
    sig_ready = 1'b1;
    tick();
    chk("f_sync_on_ready", 32'(sync_out), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("f_cleanup", 32'(busy), 32'd0);
`endif

    // Second trigger edge during GUARD is ignored
    nburst = 8'd2;
    pulse_trig();
    repeat (3) tick();
    n_sync = 0; n_tx = 0; n_ovl = 0; n_done = 0; n_busy = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 1) trig_in = 1'b0;
      if (k == 3) trig_in = 1'b1;
      n_sync += int'(sync_out);
      n_tx   += int'(tx_valid);
      n_ovl  += int'(sync_out & tx_valid);
      if (n_done > 0) n_busy += int'(busy);
      n_done += int'(done);
    end
    chk("g_sync_cycles", 32'(n_sync), 32'd8);
    chk("g_tx_cycles", 32'(n_tx), 32'd10);
    chk("g_overlap", 32'(n_ovl), 32'd0);
    chk("g_done_count", 32'(n_done), 32'd1);
    chk("g_no_requeue", 32'(n_busy), 32'd0);

    // Reset in GAP with trigger held high
    nburst = 8'd1;
    pulse_trig();
    for (int i = 0; i < 40 && !tx_valid; i++) tick();
    chk("h_tx_seen", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 20 && tx_valid; i++) tick();
    reset = 1'b1;
    tick();
    chk("h_rst_busy", 32'(busy), 32'd0);
    chk("h_rst_srst", 32'(sig_srst), 32'd1);
    chk("h_rst_outs", 32'({sync_out, tx_valid, done, aborted, err}), 32'd0);
    chk("h_rst_idx", 32'(burst_idx), 32'd0);
    tick();
    reset = 1'b0;
    n_busy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_busy += int'(busy | done | aborted);
    end
    chk("h_no_restart", 32'(n_busy), 32'd0);
    trig_in = 1'b0;
    repeat (3) tick();
    trig_in = 1'b1;
    tick(); tick();
    chk("h_new_edge_early", 32'(busy), 32'd0);
    tick();
    chk("h_new_edge_start", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    trig_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
